id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_stage.sv | 67 ++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute pipeline register bundle
interface id_ex_stage_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] Imm;
  logic [4:0]        RS1;
  logic [4:0]        RS2;
  logic [4:0]        RD;
  logic [CTRL_W-1:0] Ctrl;
  logic              Valid_in;
  logic              Flush;
  logic              WB_RegWrite;
  logic [4:0]        WB_RD;
  logic [DATA_W-1:0] WB_WriteData;
  logic [DATA_W-1:0] EX_ReadData1;
  logic [DATA_W-1:0] EX_ReadData2;
  logic [DATA_W-1:0] EX_Imm;
  logic [4:0]        EX_RS1;
  logic [4:0]        EX_RS2;
  logic [4:0]        EX_RD;
  logic [CTRL_W-1:0] EX_Ctrl;
  logic              EX_Valid;
  logic              Stall;
  logic [31:0]       BubbleCount;

  modport master (
    output ReadData1, ReadData2, Imm, RS1, RS2, RD, Ctrl, Valid_in, Flush,
           WB_RegWrite, WB_RD, WB_WriteData,
    input  EX_ReadData1, EX_ReadData2, EX_Imm, EX_RS1, EX_RS2, EX_RD,
           EX_Ctrl, EX_Valid, Stall, BubbleCount
  );

  modport slave (
    input  ReadData1, ReadData2, Imm, RS1, RS2, RD, Ctrl, Valid_in, Flush,
           WB_RegWrite, WB_RD, WB_WriteData,
    output EX_ReadData1, EX_ReadData2, EX_Imm, EX_RS1, EX_RS2, EX_RD,
           EX_Ctrl, EX_Valid, Stall, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
// Optional macro WB_BYPASS_EN forwards the same-cycle writeback value into the captured operands.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input logic         Clk,
  input logic         Reset,
  id_ex_stage_if.slave bus
);
  logic              hazard;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [31:0]       bubble_cnt;

  // A load sitting in EX whose destination is read by the instruction in decode
  always_comb begin
    hazard = bus.EX_Valid & bus.EX_Ctrl[1] & (bus.EX_RD != 5'd0) & bus.Valid_in &
             ((bus.EX_RD == bus.RS1) | (bus.EX_RD == bus.RS2));
  end

  assign bus.Stall       = hazard & ~bus.Flush;
  assign bus.BubbleCount = bubble_cnt;

`ifdef WB_BYPASS_EN
  // The register file write lands at this same edge, so its read ports still show the old value
  assign op1 = (bus.WB_RegWrite && (bus.WB_RD != 5'd0) && (bus.WB_RD == bus.RS1)) ?
               bus.WB_WriteData : bus.ReadData1;
  assign op2 = (bus.WB_RegWrite && (bus.WB_RD != 5'd0) && (bus.WB_RD == bus.RS2)) ?
               bus.WB_WriteData : bus.ReadData2;
`else
  logic unused_wb;
  assign op1       = bus.ReadData1;
  assign op2       = bus.ReadData2;
  assign unused_wb = ^{bus.WB_RegWrite, bus.WB_RD, bus.WB_WriteData};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.EX_ReadData1 <= '0;
      bus.EX_ReadData2 <= '0;
      bus.EX_Imm       <= '0;
      bus.EX_RS1       <= '0;
      bus.EX_RS2       <= '0;
      bus.EX_RD        <= '0;
      bus.EX_Ctrl      <= '0;
      bus.EX_Valid     <= 1'b0;
      bubble_cnt       <= '0;
    end else if (bus.Flush || hazard) begin
      // Bubble: only valid and control clear, data/index fields keep their old contents
      bus.EX_Valid <= 1'b0;
      bus.EX_Ctrl  <= '0;
      if (!bus.Flush && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end else begin
      bus.EX_ReadData1 <= op1;
      bus.EX_ReadData2 <= op2;
      bus.EX_Imm       <= bus.Imm;
      bus.EX_RS1       <= bus.RS1;
      bus.EX_RS2       <= bus.RS2;
      bus.EX_RD        <= bus.RD;
      bus.EX_Ctrl      <= bus.Valid_in ? bus.Ctrl : '0;
      bus.EX_Valid     <= bus.Valid_in;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a reference model
module tb_id_ex_stage;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference state of the EX side of the pipeline register
  logic [63:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [7:0]  m_ctrl;
  logic        m_valid;
  logic [31:0] m_bc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard();
    // A load in EX writes a nonzero register that decode is about to read
    return m_valid && m_ctrl[1] && (m_rd != 5'd0) && bus.Valid_in &&
           ((m_rd == bus.RS1) || (m_rd == bus.RS2));
  endfunction

  function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] rf);
`ifdef WB_BYPASS_EN
    if (bus.WB_RegWrite && bus.WB_RD != 5'd0 && bus.WB_RD == rs) return bus.WB_WriteData;
`endif
    return rf;
  endfunction

  task automatic model_edge();
    logic hz;
    hz = model_hazard();
    if (Reset) begin
      {m_rd1, m_rd2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_valid, m_bc} = '0;
    end else if (bus.Flush || hz) begin
      m_valid = 1'b0;
      m_ctrl  = 8'h00;
      if (!bus.Flush && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    end else begin
      m_rd1   = fwd(bus.RS1, bus.ReadData1);
      m_rd2   = fwd(bus.RS2, bus.ReadData2);
      m_imm   = bus.Imm;
      m_rs1   = bus.RS1;
      m_rs2   = bus.RS2;
      m_rd    = bus.RD;
      m_valid = bus.Valid_in;
      m_ctrl  = bus.Valid_in ? bus.Ctrl : 8'h00;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":rd1"},   bus.EX_ReadData1, m_rd1);
    chk({tag, ":rd2"},   bus.EX_ReadData2, m_rd2);
    chk({tag, ":imm"},   bus.EX_Imm, m_imm);
    chk({tag, ":rs1"},   64'(bus.EX_RS1), 64'(m_rs1));
    chk({tag, ":rs2"},   64'(bus.EX_RS2), 64'(m_rs2));
    chk({tag, ":rd"},    64'(bus.EX_RD), 64'(m_rd));
    chk({tag, ":ctrl"},  64'(bus.EX_Ctrl), 64'(m_ctrl));
    chk({tag, ":valid"}, 64'(bus.EX_Valid), 64'(m_valid));
    chk({tag, ":bc"},    64'(bus.BubbleCount), 64'(m_bc));
  endtask

  // Inputs are already applied; check combinational Stall, then clock and check registers
  task automatic step(input string tag);
    #1;
    chk({tag, ":stall"}, 64'(bus.Stall), 64'(model_hazard() && !bus.Flush));
    model_edge();
    @(posedge Clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [7:0] ctrl);
    bus.RS1       = rs1;
    bus.RS2       = rs2;
    bus.RD        = rd;
    bus.Ctrl      = ctrl;
    bus.Valid_in  = 1'b1;
    bus.ReadData1 = {$urandom, $urandom};
    bus.ReadData2 = {$urandom, $urandom};
    bus.Imm       = {$urandom, $urandom};
  endtask

  initial begin
    Reset            = 1'b1;
    bus.Flush        = 1'b0;
    bus.WB_RegWrite  = 1'b0;
    bus.WB_RD        = 5'd0;
    bus.WB_WriteData = 64'h0;
    {m_rd1, m_rd2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_valid, m_bc} = '0;
    set_instr(5'd1, 5'd2, 5'd3, 8'hFF);
    step("reset");
    chk("reset_valid", 64'(bus.EX_Valid), 64'd0);
    chk("reset_ctrl", 64'(bus.EX_Ctrl), 64'd0);
    Reset = 1'b0;

    set_instr(5'd5, 5'd0, 5'd7, 8'h01);
    bus.ReadData1 = 64'h1234;
    step("capture");
    chk("capture_rd1", bus.EX_ReadData1, 64'h1234);
    chk("capture_rdidx", 64'(bus.EX_RD), 64'd7);
    chk("capture_ctrl", 64'(bus.EX_Ctrl), 64'h01);
    chk("capture_valid", 64'(bus.EX_Valid), 64'd1);

    set_instr(5'd1, 5'd2, 5'd3, 8'h0B);
    step("load");
    set_instr(5'd0, 5'd3, 5'd4, 8'h01);
    #1;
    chk("loaduse_stall", 64'(bus.Stall), 64'd1);
    step("loaduse");
    chk("bubble_valid", 64'(bus.EX_Valid), 64'd0);
    chk("bubble_count", 64'(bus.BubbleCount), 64'd1);
    step("after_bubble");

    set_instr(5'd1, 5'd2, 5'd3, 8'h0B);
    step("load2");
    set_instr(5'd0, 5'd3, 5'd4, 8'h01);
    bus.Flush = 1'b1;
    #1;
    chk("flush_stall", 64'(bus.Stall), 64'd0);
    step("flush_hazard");
    chk("flush_count", 64'(bus.BubbleCount), 64'd1);
    chk("flush_valid", 64'(bus.EX_Valid), 64'd0);
    bus.Flush = 1'b0;

    set_instr(5'd4, 5'd0, 5'd5, 8'h01);
    bus.ReadData1    = 64'h0;
    bus.WB_RegWrite  = 1'b1;
    bus.WB_RD        = 5'd4;
    bus.WB_WriteData = 64'hDEAD;
    step("bypass");
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", bus.EX_ReadData1, 64'hDEAD);
`else
    chk("bypass_rd1", bus.EX_ReadData1, 64'h0);
`endif
    set_instr(5'd0, 5'd0, 5'd5, 8'h01);
    bus.ReadData1 = 64'h0;
    bus.WB_RD     = 5'd0;
    step("bypass_x0");
    chk("bypass_x0_rd1", bus.EX_ReadData1, 64'h0);

    for (int i = 0; i < 400; i++) begin
      set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 8'($urandom));
      bus.Valid_in     = ($urandom_range(0, 9) < 8);
      bus.Flush        = ($urandom_range(0, 9) == 0);
      Reset            = ($urandom_range(0, 49) == 0);
      bus.WB_RegWrite  = $urandom_range(0, 1) == 1;
      bus.WB_RD        = 5'($urandom_range(0, 3));
      bus.WB_WriteData = {$urandom, $urandom};
      step("random");
    end
    Reset = 1'b0;
    bus.Flush = 1'b0;
    bus.WB_RegWrite = 1'b0;

    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt;
    m_bc = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      set_instr(5'd1, 5'd2, 5'd9, 8'h0B);
      step("sat_load");
      set_instr(5'd9, 5'd0, 5'd10, 8'h01);
      step("sat_hazard");
    end
    chk("saturate", 64'(bus.BubbleCount), 64'hFFFF_FFFF);

    set_instr(5'd1, 5'd2, 5'd6, 8'h0B);
    step("rst_load");
    set_instr(5'd6, 5'd0, 5'd8, 8'h01);
    Reset = 1'b1;
    step("rst_override");
    chk("rst_override_bc", 64'(bus.BubbleCount), 64'd0);
    Reset = 1'b0;
    #1;
    chk("post_reset_stall", 64'(bus.Stall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
